mmm_exp_ctrl: RTL and testbench

//   Sequencer for one Montgomery modular multiplier (mmm_unit): computes C = P^E mod N by left-to-right square-and-multiply.

---
 rtl/mmm_exp_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mmm_exp_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mmm_exp_ctrl.sv
// Square-and-multiply sequencer driving one Montgomery multiplier: C = P^E mod N.
// Build option MMM_EXP_SKIP_LZ_EN skips the squarings above the exponent MSB.
module mmm_exp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] const_r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mmm_en,
  output logic             mmm_rst,
  output logic             mmm_ld_a,
  output logic             mmm_ld_r,
  output logic             mmm_lock,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  output logic [WIDTH-1:0] mmm_m,
  input  logic [WIDTH-1:0] mmm_r
);

  // state | meaning
  // IDLE  | waiting for start
  // TO_P  | Pm = MMM(P, R2)
  // TO_1  | X  = MMM(1, R2)
  // SQ    | X  = MMM(X, X) for bit i
  // MUL   | X  = MMM(X, Pm) when E[i] = 1
  // FROM  | result = MMM(X, 1)
  // FIN   | last product lands in result
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, TO_P, TO_1, SQ, MUL, FROM, FIN, DONE} state_t;

  localparam int OP_CYCLES = WIDTH + 3;
  localparam int CW = $clog2(OP_CYCLES);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    PH_CLR  = CW'(OP_CYCLES - 1);
  localparam logic [CW-1:0]    PH_LOAD = CW'(OP_CYCLES - 2);
  localparam logic [BW-1:0]    BIT_TOP = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, state_nxt, cap_op;
  logic [CW-1:0]    ph_cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] p_q, e_q, n_q, r2_q, x_q, pm_q, x_cur, pm_cur;
  logic             accept, in_op, op_end, ph_clr;

  assign accept = (state == IDLE) && start;
  assign in_op  = state inside {TO_P, TO_1, SQ, MUL, FROM};
  assign op_end = in_op && (ph_cnt == '0);
  assign ph_clr = in_op && (ph_cnt == PH_CLR);

`ifdef MMM_EXP_SKIP_LZ_EN
  logic [BW-1:0] msb_idx;
  always_comb begin
    msb_idx = '0;
    for (int k = 0; k < WIDTH; k++)
      if (e_q[k]) msb_idx = BW'(k);
  end
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = TO_P;
      TO_P: if (op_end) state_nxt = TO_1;
      TO_1: if (op_end) begin
`ifdef MMM_EXP_SKIP_LZ_EN
        state_nxt = (e_q == '0) ? FROM : SQ;
`else
        state_nxt = SQ;
`endif
      end
      SQ: if (op_end) begin
        if (e_q[bit_idx])         state_nxt = MUL;
        else if (bit_idx == '0)   state_nxt = FROM;
        else                      state_nxt = SQ;
      end
      MUL:  if (op_end) state_nxt = (bit_idx == '0) ? FROM : SQ;
      FROM: if (op_end) state_nxt = FIN;
      FIN:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sub-phase timer: CLR at the top count, CAPT at terminal count zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                ph_cnt <= PH_CLR;
    else if (!in_op || op_end) ph_cnt <= PH_CLR;
    else                      ph_cnt <= ph_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) bit_idx <= '0;
    else if (accept) bit_idx <= BIT_TOP;
`ifdef MMM_EXP_SKIP_LZ_EN
    else if (op_end && state == TO_1) bit_idx <= msb_idx;
`endif
    else if (op_end && bit_idx != '0 && ((state == SQ && !e_q[bit_idx]) || state == MUL))
      bit_idx <= bit_idx - BW'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cap_op <= IDLE;
    else       cap_op <= op_end ? state : IDLE;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      r2_q   <= '0;
      x_q    <= '0;
      pm_q   <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        p_q  <= msg;
        e_q  <= exponent;
        n_q  <= modulus;
        r2_q <= const_r2;
      end
      case (cap_op)
        TO_P:          pm_q   <= mmm_r;
        TO_1, SQ, MUL: x_q    <= mmm_r;
        FROM:          result <= mmm_r;
        default: ;
      endcase
    end
  end

  // The product is captured during the next op's CLR; forward it so A/B hold for the whole op.
  assign x_cur  = (cap_op inside {TO_1, SQ, MUL}) ? mmm_r : x_q;
  assign pm_cur = (cap_op == TO_P) ? mmm_r : pm_q;
  assign mmm_m  = n_q;

  always_comb begin
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    mmm_lock = !in_op;
    mmm_rst  = !ph_clr;
    mmm_ld_a = in_op && (ph_cnt == PH_LOAD);
    mmm_ld_r = op_end;
    mmm_en   = in_op && !ph_clr;
    mmm_a    = '0;
    mmm_b    = '0;
    case (state)
      TO_P: begin mmm_a = p_q;   mmm_b = r2_q;   end
      TO_1: begin mmm_a = ONE;   mmm_b = r2_q;   end
      SQ:   begin mmm_a = x_cur; mmm_b = x_cur;  end
      MUL:  begin mmm_a = x_cur; mmm_b = pm_cur; end
      FROM: begin mmm_a = x_cur; mmm_b = ONE;    end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmm_exp_ctrl.sv
// Bench for mmm_exp_ctrl with a behavioural Montgomery multiplier model on the mmm_* side.
`timescale 1ns/1ps
module tb_mmm_exp_ctrl;
  localparam int W   = 8;
  localparam int OPC = W + 3;

  logic         clk, rstb, start;
  logic [W-1:0] msg, exponent, modulus, const_r2;
  logic         busy, done;
  logic [W-1:0] result;
  logic         mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock;
  logic [W-1:0] mmm_a, mmm_b, mmm_m, mmm_r;
  int           n_chk, n_pass;

  mmm_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .start(start),
    .msg(msg), .exponent(exponent), .modulus(modulus), .const_r2(const_r2),
    .busy(busy), .done(done), .result(result),
    .mmm_en(mmm_en), .mmm_rst(mmm_rst), .mmm_ld_a(mmm_ld_a), .mmm_ld_r(mmm_ld_r),
    .mmm_lock(mmm_lock), .mmm_a(mmm_a), .mmm_b(mmm_b), .mmm_m(mmm_m), .mmm_r(mmm_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MMM(a,b) = a*b*R^-1 mod m, found by search for x with x*R == a*b (mod m).
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W-1:0] res;
    int ab;
    res = '0;
    if (m != '0) begin
      ab = (int'(a) * int'(b)) % int'(m);
      for (int x = int'(m) - 1; x >= 0; x--)
        if (((x << W) % int'(m)) == ab) res = W'(x);
    end
    return res;
  endfunction

  logic [W-1:0] la, lb;
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mmm_r <= '0; la <= '0; lb <= '0;
    end else if (!mmm_rst) begin
      mmm_r <= '0;
    end else if (mmm_en) begin
      if (mmm_ld_a) begin la <= mmm_a; lb <= mmm_b; end
      if (mmm_ld_r) mmm_r <= mont(la, lb, mmm_m);
    end
  end

  logic [38:0] outs_w;
  localparam logic [38:0] RST_OUTS = {2'b00, 8'h00, 5'b01001, 24'h000000};
  assign outs_w = {busy, done, result, mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock,
                   mmm_a, mmm_b, mmm_m};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] p, e, n, r2, res;
    int           lat;
  } vec_t;

  vec_t vecs[6];
  int   lat_tab[6];

  // inj > 0: pulse start with junk inputs at that cycle; inj < 0: pulse it in the DONE cycle.
  task automatic run_vec(input vec_t v, input string tag, input int inj);
    int cyc, n_rst, n_lda, n_ldr, n_en, n_lock, n_bad, ops;
    logic got, busy_ok, prev_clr, done_busy;
    logic [W-1:0] a0, b0;
    @(posedge clk); #1;
    msg = v.p; exponent = v.e; modulus = v.n; const_r2 = v.r2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 1'b0; busy_ok = 1'b1; prev_clr = 1'b0; done_busy = 1'b0;
    n_rst = 0; n_lda = 0; n_ldr = 0; n_en = 0; n_lock = 0; n_bad = 0;
    a0 = '0; b0 = '0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_busy = busy;
        if (inj < 0) begin
          start = 1'b1; msg = 8'h3C; exponent = 8'h00; modulus = 8'hC3; const_r2 = 8'h11;
        end
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (!mmm_rst) begin n_rst++; a0 = mmm_a; b0 = mmm_b; end
        if (mmm_ld_a) begin n_lda++; if (!prev_clr) n_bad++; end
        if (mmm_ld_r) n_ldr++;
        if (mmm_en) n_en++;
        if (!mmm_lock) begin
          n_lock++;
          if (mmm_a !== a0 || mmm_b !== b0 || mmm_m !== v.n) n_bad++;
        end
        prev_clr = !mmm_rst;
        @(posedge clk); #1;
        cyc++;
        if (cyc == inj) begin
          start = 1'b1; msg = 8'h3C; exponent = 8'h00; modulus = 8'hC3; const_r2 = 8'h11;
        end else start = 1'b0;
      end
    end
    ops = (v.lat - 2) / OPC;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    check({tag, "_result"}, 64'(result), 64'(v.res));
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
    check({tag, "_strobe_pulses"}, {16'(n_rst), 16'(n_lda), 16'(n_ldr)},
          {16'(ops), 16'(ops), 16'(ops)});
    check({tag, "_strobe_lengths"}, {32'(n_en), 32'(n_lock)}, {32'(ops * (W + 2)), 32'(ops * OPC)});
    check({tag, "_operand_stable"}, 64'(n_bad), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_after_done"}, {busy, done, result}, {1'b0, 1'b0, v.res});
  endtask

  initial begin
    logic idle_ok;
    n_chk = 0; n_pass = 0;
    rstb = 1'b0; start = 1'b0;
    msg = '0; exponent = '0; modulus = '0; const_r2 = '0;

`ifdef MMM_EXP_SKIP_LZ_EN
    lat_tab = '{101, 35, 211, 101, 79, 90};
`else
    lat_tab = '{156, 123, 211, 134, 145, 145};
`endif
    vecs[0] = '{p: 8'd88,  e: 8'd7,   n: 8'd187, r2: 8'd86, res: 8'd11,  lat: lat_tab[0]};
    vecs[1] = '{p: 8'd5,   e: 8'd0,   n: 8'd187, r2: 8'd86, res: 8'd1,   lat: lat_tab[1]};
    vecs[2] = '{p: 8'd2,   e: 8'hFF,  n: 8'd187, r2: 8'd86, res: 8'd43,  lat: lat_tab[2]};
    vecs[3] = '{p: 8'd3,   e: 8'h10,  n: 8'd187, r2: 8'd86, res: 8'd69,  lat: lat_tab[3]};
    vecs[4] = '{p: 8'd186, e: 8'd3,   n: 8'd187, r2: 8'd86, res: 8'd186, lat: lat_tab[4]};
    vecs[5] = '{p: 8'd0,   e: 8'd5,   n: 8'd187, r2: 8'd86, res: 8'd0,   lat: lat_tab[5]};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(outs_w), 64'(RST_OUTS));
    rstb = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

    // Abort mid-operation with reset, then confirm a clean rerun.
    @(posedge clk); #1;
    msg = vecs[0].p; exponent = vecs[0].e; modulus = vecs[0].n; const_r2 = vecs[0].r2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rstb = 1'b0;
    #1;
    check("midop_reset_outputs", 64'(outs_w), 64'(RST_OUTS));
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    idle_ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy || done || !mmm_lock || !mmm_rst) idle_ok = 1'b0;
    end
    check("post_reset_idle", 64'(idle_ok), 64'd1);
    run_vec(vecs[0], "rerun", 0);

    run_vec(vecs[0], "busy_start", 50);
    run_vec(vecs[2], "done_start", -1);
    idle_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || done || result !== vecs[2].res) idle_ok = 1'b0;
    end
    check("done_start_ignored", 64'(idle_ok), 64'd1);
    run_vec(vecs[1], "resample", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
